// File: rtl/mem_stage_sram_pkg.sv
// Shared types and defaults for the ARM pipeline memory stage.
//   state_t     : sram_ctrl FSM state (IDLE, ACCESS, DONE)
//   word_t      : 32-bit data/address word
//   DEF_*       : default parameter values for the stage
//   word_offset : byte address -> word offset relative to a base address
package mem_stage_sram_pkg;

  localparam int unsigned DEF_WAIT_CYCLES = 5;
  localparam int unsigned DEF_ADDR_BASE   = 1024;
  localparam int unsigned DEF_SRAM_AW     = 16;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Subtract the mapping base and drop the byte-lane bits. Callers keep as
  // many low bits as the SRAM address is wide, which gives the wrap-around.
  function automatic word_t word_offset(input word_t byte_addr, input word_t base);
    word_t diff;
    diff = byte_addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// SRAM access controller: FSM, wait counter, strobe/address generation,
// pipeline freeze and load-data capture.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_mem_r_en, i_mem_w_en    load / store request (store wins if both)
//   i_byte_addr, i_wdata      byte address and store data
//   i_sram_rdata              SRAM read data
//   o_freeze                  pipeline stall
//   o_sram_*                  SRAM word address, write data, active-low strobes
//   o_rdata, o_rdata_valid    captured load data; valid during DONE of a load
//   o_state                   current FSM state (debug visibility)
//
// Request/freeze handshake: a request is "valid" while mem_r_en/mem_w_en is
// high; the stage is "ready" (accepts it) on the rising edge where freeze is
// low. The requester holds the request unchanged while freeze is high. The
// request is still present during DONE, but DONE never re-launches it.
module mem_stage_sram_ctrl
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mem_r_en,
  input  logic               i_mem_w_en,
  input  word_t              i_byte_addr,
  input  word_t              i_wdata,
  input  word_t              i_sram_rdata,
  output logic               o_freeze,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output word_t              o_sram_wdata,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output word_t              o_rdata,
  output logic               o_rdata_valid,
  output state_t             o_state
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_load;
  logic               r_we_n;
  logic               r_oe_n;
  logic [SRAM_AW-1:0] r_addr;
  word_t              r_wdata;
  word_t              r_rdata;

  logic               w_req;
  logic [SRAM_AW-1:0] w_addr;

  assign w_req  = i_mem_r_en || i_mem_w_en;
  assign w_addr = SRAM_AW'(word_offset(i_byte_addr, word_t'(ADDR_BASE)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_is_load <= 1'b0;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state   <= ST_ACCESS;
            r_cnt     <= CNT_LOAD;
            r_addr    <= w_addr;
            r_wdata   <= i_wdata;
            // A simultaneous read/write request is performed as a store.
            r_is_load <= !i_mem_w_en;
            r_we_n    <= !i_mem_w_en;
            r_oe_n    <= i_mem_w_en;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            if (r_is_load) r_rdata <= i_sram_rdata;
            r_state <= ST_DONE;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Freeze must rise in the same cycle the request appears so the upstream
  // registers never advance past it; it is gated by reset so an abort drops
  // the stall immediately even while the request is still driven.
  assign o_freeze = i_rst_n &&
                    ((r_state == ST_ACCESS) || ((r_state == ST_IDLE) && w_req));

  assign o_sram_addr   = r_addr;
  assign o_sram_wdata  = r_wdata;
  assign o_sram_we_n   = r_we_n;
  assign o_sram_oe_n   = r_oe_n;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = (r_state == ST_DONE) && r_is_load;
  assign o_state       = r_state;

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage of the ARM pipeline: performs loads/stores against an
// external single-port SRAM (via mem_stage_sram_ctrl) and holds the MEM/WB
// pipeline register feeding write-back.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   wb_en_in .. val_rm_in     EXE/MEM register outputs
//   sram_rdata                SRAM read data
//   freeze                    stall to upstream stage registers and PC
//   sram_addr .. sram_oe_n    SRAM word address, write data, strobes
//   wb_en_out .. mem_rdata_out MEM/WB register outputs
//   dbg_state                 sram_ctrl FSM state (0 IDLE, 1 ACCESS, 2 DONE)
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [3:0]         dest_in,
  input  logic [31:0]        alu_res_in,
  input  logic [31:0]        val_rm_in,
  input  logic [31:0]        sram_rdata,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [3:0]         dest_out,
  output logic [31:0]        alu_res_out,
  output logic [31:0]        mem_rdata_out,
  output logic [1:0]         dbg_state
);

  logic   w_freeze;
  word_t  w_rdata;
  logic   w_rdata_valid;
  state_t w_state;

  logic        r_wb_en;
  logic        r_mem_r_en;
  logic [3:0]  r_dest;
  word_t       r_alu_res;
  word_t       r_mem_rdata;

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .ADDR_BASE   (ADDR_BASE),
    .SRAM_AW     (SRAM_AW)
  ) u_sram_ctrl (
    .i_clk         (clk),
    .i_rst_n       (rst),
    .i_mem_r_en    (mem_r_en_in),
    .i_mem_w_en    (mem_w_en_in),
    .i_byte_addr   (alu_res_in),
    .i_wdata       (val_rm_in),
    .i_sram_rdata  (sram_rdata),
    .o_freeze      (w_freeze),
    .o_sram_addr   (sram_addr),
    .o_sram_wdata  (sram_wdata),
    .o_sram_we_n   (sram_we_n),
    .o_sram_oe_n   (sram_oe_n),
    .o_rdata       (w_rdata),
    .o_rdata_valid (w_rdata_valid),
    .o_state       (w_state)
  );

  // MEM/WB register. While frozen the enables become a bubble so the held
  // instruction writes back exactly once, on the edge ending DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en     <= 1'b0;
      r_mem_r_en  <= 1'b0;
      r_dest      <= '0;
      r_alu_res   <= '0;
      r_mem_rdata <= '0;
    end else if (w_freeze) begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
    end else begin
      r_wb_en    <= wb_en_in;
      r_mem_r_en <= mem_r_en_in;
      r_dest     <= dest_in;
      r_alu_res  <= alu_res_in;
      if (w_rdata_valid) r_mem_rdata <= w_rdata;
    end
  end

  assign freeze        = w_freeze;
  assign wb_en_out     = r_wb_en;
  assign mem_r_en_out  = r_mem_r_en;
  assign dest_out      = r_dest;
  assign alu_res_out   = r_alu_res;
  assign mem_rdata_out = r_mem_rdata;
  assign dbg_state     = w_state;

endmodule
